// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART transmitter. Serialises one byte per request as a
//                10-bit frame (start 0, 8 data bits LSB-first, stop 1), each
//                bit held for CLKS_PER_BIT clocks. Reports busy/done to the
//                host-side controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Period counter is sized for 0..CLKS_PER_BIT-1; a one-bit floor keeps
    // the declaration legal even for the smallest period.
    localparam int unsigned      CNT_W         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST_DATA = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [9:0]       shreg_q;   // frame shift register, bit 0 drives the line
    logic [CNT_W-1:0] cnt_q;     // clocks elapsed within the current bit
    logic [3:0]       bit_q;     // index of the bit on the line, 0..9
    logic             busy_q;
    logic             done_q;

    logic             w_period_end;

    assign w_period_end = (cnt_q == CNT_LAST);

    // Frame sequencer: accepts a byte in IDLE, then shifts one bit out per
    // period until the stop bit has been held for a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        // Start bit lands in bit 0, so the line drops at this edge.
                        shreg_q <= {1'b1, tx_data, 1'b0};
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    if (w_period_end) begin
                        cnt_q   <= '0;
                        // Ones shift in at the top, so the line is already
                        // high once the whole frame has been shifted out.
                        shreg_q <= {1'b1, shreg_q[9:1]};
                        if (state_q == S_STOP) begin
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            if (state_q == S_START) begin
                                state_q <= S_DATA;
                            end else if (bit_q == BIT_LAST_DATA) begin
                                state_q <= S_STOP;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign serial_out = shreg_q[0];
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Self-checking bench for uart_tx_frame. Three instances
//                (CLKS_PER_BIT = 10, 2, 16) share stimulus; a frame-level
//                model predicts every output on every cycle, and directed
//                scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int NL = 3;

    function automatic int cpb_of(input int l);
        case (l)
            0:       return 10;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [NL-1:0] so;
    logic [NL-1:0] busy;
    logic [NL-1:0] done;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(10)) u_dut10 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    // A lane is either idle or k cycles into a frame of 10*C cycles; the line
    // carries frame bit k/C. The done pulse is the first cycle after the frame.
    bit         m_active [NL];
    int         m_k      [NL];
    logic [9:0] m_frame  [NL];
    bit         m_done   [NL];

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                m_active[l] = 1'b0;
                m_done[l]   = 1'b0;
            end else begin
                m_done[l] = 1'b0;
                if (m_active[l]) begin
                    m_k[l]++;
                    if (m_k[l] == 10 * cpb_of(l)) begin
                        m_active[l] = 1'b0;
                        m_done[l]   = 1'b1;
                    end
                end else if (tx_start) begin
                    m_active[l] = 1'b1;
                    m_k[l]      = 0;
                    m_frame[l]  = {1'b1, tx_data, 1'b0};
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < NL; l++) begin
                logic e_so;
                e_so = m_active[l] ? m_frame[l][m_k[l] / cpb_of(l)] : 1'b1;
                chk("serial_out", l, 32'(so[l]),   32'(e_so));
                chk("tx_busy",    l, 32'(busy[l]), 32'(m_active[l]));
                chk("tx_done",    l, 32'(done[l]), 32'(m_done[l]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic cap_so   [NL][0:240];
    logic cap_busy [NL][0:240];
    logic cap_done [NL][0:240];

    // Record n samples starting at the current negedge (sample 1 is the first
    // negedge after an acceptance edge). Optionally pulse tx_start mid-way.
    task automatic capture(input int n, input int pulse_at, input logic [7:0] pd);
        for (int i = 1; i <= n; i++) begin
            for (int l = 0; l < NL; l++) begin
                cap_so[l][i]   = so[l];
                cap_busy[l][i] = busy[l];
                cap_done[l][i] = done[l];
            end
            if (pulse_at > 0 && i == pulse_at) begin
                tx_start = 1'b1;
                tx_data  = pd;
            end
            if (pulse_at > 0 && i == pulse_at + 1) begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy != '0 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("idle_timeout", cnt, 32'(cnt < 500), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Every bit period of lane l must hold pat[b] for all of its C samples.
    task automatic check_frame(input string nm, input int l, input logic [9:0] pat);
        int c;
        c = cpb_of(l);
        for (int b = 0; b < 10; b++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 1; j <= c; j++) begin
                if (cap_so[l][b * c + j] !== pat[b]) ok = 1'b0;
            end
            chk(nm, b, 32'(ok), 32'd1);
        end
    endtask

    function automatic int count_busy(input int l, input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) if (cap_busy[l][i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int count_done(input int l, input int n);
        int s;
        s = 0;
        for (int i = 1; i <= n; i++) if (cap_done[l][i] === 1'b1) s++;
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset held with tx_start asserted; model expects idle outputs.
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        tx_start = 1'b0;
        @(negedge clk);
        chk("rst_so",   0, 32'(so[0]),   32'd1);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_done", 0, 32'(done[0]), 32'd0);

        // Single frame A5: 0,1,0,1,0,0,1,0,1,1
        pulse(8'hA5);
        capture(180, 0, 8'h00);
        check_frame("a5_bit", 0, 10'b1101001010);
        chk("a5_busy_len", 0, 32'(count_busy(0, 180)), 32'd100);
        chk("a5_done_cnt", 0, 32'(count_done(0, 180)), 32'd1);
        chk("a5_done_pos", 0, 32'(cap_done[0][101]),  32'd1);
        wait_idle();

        // Busy rejection: 3C then FF pulsed at cycle 45.
        pulse(8'h3C);
        capture(150, 44, 8'hFF);
        check_frame("3c_bit", 0, 10'b1001111000);
        chk("3c_busy_len", 0, 32'(count_busy(0, 150)), 32'd100);
        chk("3c_done_cnt", 0, 32'(count_done(0, 150)), 32'd1);
        wait_idle();

        // Back-to-back: start held, 00 then FF.
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_data  = 8'hFF;
        capture(215, 0, 8'h00);
        tx_start = 1'b0;
        begin
            bit gap_ok;
            gap_ok = 1'b1;
            for (int i = 91; i <= 101; i++) if (cap_so[0][i] !== 1'b1) gap_ok = 1'b0;
            chk("b2b_gap_high",  0, 32'(gap_ok),           32'd1);
        end
        chk("b2b_start2",    0, 32'(cap_so[0][102]),    32'd0);
        chk("b2b_data2",     0, 32'(cap_so[0][112]),    32'd1);
        chk("b2b_done_cnt",  0, 32'(count_done(0, 202)), 32'd2);
        chk("b2b_done_pos2", 0, 32'(cap_done[0][202]),  32'd1);
        wait_idle();

        // Mid-frame reset during data bit 4 of 81.
        pulse(8'h81);
        repeat (54) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_so",   0, 32'(so[0]),   32'd1);
        chk("mrst_busy", 0, 32'(busy[0]), 32'd0);
        capture(60, 0, 8'h00);
        chk("mrst_no_done", 0, 32'(count_done(0, 60)), 32'd0);
        chk("mrst_no_busy", 0, 32'(count_busy(0, 60)), 32'd0);
        pulse(8'h81);
        capture(110, 0, 8'h00);
        check_frame("81_bit", 0, 10'b1100000010);
        chk("81_done_pos", 0, 32'(cap_done[0][101]), 32'd1);
        wait_idle();

        // Parameter sweep with 55 on the C=2 and C=16 lanes.
        pulse(8'h55);
        capture(180, 0, 8'h00);
        check_frame("55_c2_bit",  1, 10'b1010101010);
        check_frame("55_c16_bit", 2, 10'b1010101010);
        chk("55_c2_len",  1, 32'(count_busy(1, 180)), 32'd20);
        chk("55_c16_len", 2, 32'(count_busy(2, 180)), 32'd160);
        wait_idle();

        // Randomised traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 80; it++) begin
            int r;
            int hold;
            r    = $urandom_range(0, 19);
            hold = $urandom_range(1, 40);
            @(negedge clk);
            if (r == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tx_start = (r < 8) ? 1'b1 : 1'b0;
                for (int h = 0; h < hold; h++) begin
                    tx_data = 8'($urandom);
                    if (r >= 8 && $urandom_range(0, 9) == 0) tx_start = ~tx_start;
                    @(negedge clk);
                end
                tx_start = 1'b0;
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
